// File: rtl/gpio_input_conditioner.sv
// Per-pin GPIO input conditioning: 2-flop synchroniser, debounce, registered rise/fall strobes.
// Optional sticky edge status and interrupt output are enabled by GPIO_INPUT_CONDITIONER_IRQ_EN.
module gpio_input_conditioner #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic             io_clock,
    input  logic             io_resetn,
    input  logic [WIDTH-1:0] io_pins_raw,
    input  logic [WIDTH-1:0] io_pins_writeEnable,
    output logic [WIDTH-1:0] io_pins_read,
    output logic [WIDTH-1:0] io_rise,
    output logic [WIDTH-1:0] io_fall
`ifdef GPIO_INPUT_CONDITIONER_IRQ_EN
    ,
    input  logic [WIDTH-1:0] io_edgeClear,
    output logic [WIDTH-1:0] io_edgeStatus,
    output logic             io_irq
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_reg;
    logic [WIDTH-1:0] sync2_reg;
    logic [WIDTH-1:0] stable_reg;
    logic [WIDTH-1:0] stable_next;
    logic [WIDTH-1:0] rise_reg;
    logic [WIDTH-1:0] fall_reg;

    // Plain two-stage synchroniser; nothing may sit between the stages.
    always_ff @(posedge io_clock or negedge io_resetn) begin
        if (!io_resetn) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= io_pins_raw;
            sync2_reg <= sync1_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_pin
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic             stable_bit_next;

            // Driven pins track sync2 directly; otherwise a change must hold
            // for DEBOUNCE_CYCLES consecutive cycles, any bounce back restarts.
            always_comb begin
                stable_bit_next = stable_reg[gi];
                cnt_next        = cnt_reg;
                if (io_pins_writeEnable[gi]) begin
                    stable_bit_next = sync2_reg[gi];
                    cnt_next        = '0;
                end else if (sync2_reg[gi] == stable_reg[gi]) begin
                    cnt_next = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    stable_bit_next = sync2_reg[gi];
                    cnt_next        = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            assign stable_next[gi] = stable_bit_next;

            always_ff @(posedge io_clock or negedge io_resetn) begin
                if (!io_resetn) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end
        end
    endgenerate

    // Strobes are registered alongside stable so they line up with the read value.
    always_ff @(posedge io_clock or negedge io_resetn) begin
        if (!io_resetn) begin
            stable_reg <= '0;
            rise_reg   <= '0;
            fall_reg   <= '0;
        end else begin
            stable_reg <= stable_next;
            rise_reg   <= ~stable_reg & stable_next;
            fall_reg   <= stable_reg & ~stable_next;
        end
    end

    assign io_pins_read = stable_reg;
    assign io_rise      = rise_reg;
    assign io_fall      = fall_reg;

`ifdef GPIO_INPUT_CONDITIONER_IRQ_EN
    logic [WIDTH-1:0] status_reg;
    logic             irq_reg;

    // Set takes priority over a same-cycle clear so no edge is ever lost.
    always_ff @(posedge io_clock or negedge io_resetn) begin
        if (!io_resetn) begin
            status_reg <= '0;
            irq_reg    <= 1'b0;
        end else begin
            status_reg <= (status_reg & ~io_edgeClear) | rise_reg | fall_reg;
            irq_reg    <= |status_reg;
        end
    end

    assign io_edgeStatus = status_reg;
    assign io_irq        = irq_reg;
`endif

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Directed bench for gpio_input_conditioner with a per-cycle expectation scoreboard.
// Build with GPIO_INPUT_CONDITIONER_IRQ_EN defined to also exercise the edge status/irq path.
module tb_gpio_input_conditioner;

    localparam int W = 4;
    localparam int D = 4;

    typedef struct {
        string      tag;
        logic [3:0] read;
        logic [3:0] rise;
        logic [3:0] fall;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] raw;
    logic [W-1:0] we;
    logic [W-1:0] read;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
`ifdef GPIO_INPUT_CONDITIONER_IRQ_EN
    logic [W-1:0] clr;
    logic [W-1:0] status;
    logic         irq;
`endif

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    gpio_input_conditioner #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(D),
        .CNT_W(16)
    ) dut (
        .io_clock(clk),
        .io_resetn(rst_n),
        .io_pins_raw(raw),
        .io_pins_writeEnable(we),
        .io_pins_read(read),
        .io_rise(rise),
        .io_fall(fall)
`ifdef GPIO_INPUT_CONDITIONER_IRQ_EN
        ,
        .io_edgeClear(clr),
        .io_edgeStatus(status),
        .io_irq(irq)
`endif
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Queue the expectation for the next edge, advance one clock, then retire it.
    task automatic tick(input string tag, input logic [3:0] r, input logic [3:0] ri, input logic [3:0] f);
        exp_t e;
        e.tag  = tag;
        e.read = r;
        e.rise = ri;
        e.fall = f;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".read"}, read, e.read);
        chk({e.tag, ".rise"}, rise, e.rise);
        chk({e.tag, ".fall"}, fall, e.fall);
        $display("cycle %s: read=%h rise=%h fall=%h", e.tag, read, rise, fall);
    endtask

    task automatic hold(input string tag, input int n, input logic [3:0] r);
        for (int i = 0; i < n; i++) tick(tag, r, 4'h0, 4'h0);
    endtask

    initial begin
        logic hist [0:11];
        logic exp2;
        logic prev2;

        rst_n = 1'b0;
        raw   = '0;
        we    = '0;
`ifdef GPIO_INPUT_CONDITIONER_IRQ_EN
        clr   = '0;
`endif
        #2;
        chk("reset.read", read, 4'h0);
        chk("reset.rise", rise, 4'h0);
        chk("reset.fall", fall, 4'h0);
        hold("in_reset", 2, 4'h0);
        rst_n = 1'b1;
        hold("idle", 2, 4'h0);

        // Bit 0 held high: accepted on edge D+1 after first capture.
        raw[0] = 1'b1;
        hold("b0_wait", D + 1, 4'h0);
        tick("b0_accept", 4'h1, 4'h1, 4'h0);
        hold("b0_after", 2, 4'h1);

        // Bit 1 glitch of D-1 cycles must be rejected.
        raw[1] = 1'b1;
        hold("b1_glitch", D - 1, 4'h1);
        raw[1] = 1'b0;
        hold("b1_reject", 6, 4'h1);
        // Full-length count afterwards proves the partial count was discarded.
        raw[1] = 1'b1;
        hold("b1_wait", D + 1, 4'h1);
        tick("b1_accept", 4'h3, 4'h2, 4'h0);
        hold("b1_after", 1, 4'h3);

        // Driven pin 2 bypasses debounce with two-cycle latency.
        we[2] = 1'b1;
        prev2 = 1'b0;
        for (int k = 0; k < 12; k++) begin
            raw[2]  = ((k / 3) % 2) == 0;
            hist[k] = raw[2];
            exp2    = (k >= 2) ? hist[k-2] : 1'b0;
            tick("b2_we", {1'b0, exp2, 2'b11}, {1'b0, exp2 & ~prev2, 2'b00},
                 {1'b0, ~exp2 & prev2, 2'b00});
            prev2 = exp2;
        end
        hold("b2_done", 1, 4'h3);

        raw = 4'h0;
        we  = 4'h0;
        hold("fall_wait", D + 1, 4'h3);
        tick("fall_accept", 4'h0, 4'h0, 4'h3);
        hold("fall_after", 1, 4'h0);

        // Simultaneous rise on bits 0 and 3.
        raw = 4'b1001;
        hold("b03_wait", D + 1, 4'h0);
        tick("b03_accept", 4'h9, 4'h9, 4'h0);
        hold("b03_after", 2, 4'h9);

        // Reset pulse mid-count clears everything immediately.
        raw = 4'hF;
        hold("all_count", 2, 4'h9);
        rst_n = 1'b0;
        #1;
        chk("async_rst.read", read, 4'h0);
        chk("async_rst.rise", rise, 4'h0);
        chk("async_rst.fall", fall, 4'h0);
        tick("rst_pulse", 4'h0, 4'h0, 4'h0);
        rst_n = 1'b1;
        hold("post_rst_wait", D + 1, 4'h0);
        tick("post_rst_accept", 4'hF, 4'hF, 4'h0);
        hold("post_rst_after", 3, 4'hF);

`ifdef GPIO_INPUT_CONDITIONER_IRQ_EN
        chk("irq.status_after_rise", status, 4'hF);
        chk("irq.irq_after_rise", {3'b0, irq}, 4'h1);
        clr = 4'hF;
        hold("irq_clear_all", 2, 4'hF);
        chk("irq.status_cleared", status, 4'h0);
        chk("irq.irq_cleared", {3'b0, irq}, 4'h0);
        clr = 4'h0;

        // Bring bit 0 low through the driven path, then clear its status.
        we[0]  = 1'b1;
        raw[0] = 1'b0;
        hold("irq_b0_low", 2, 4'hF);
        tick("irq_b0_fall", 4'hE, 4'h0, 4'h1);
        hold("irq_b0_low2", 1, 4'hE);
        clr = 4'h1;
        hold("irq_clr1", 1, 4'hE);
        clr = 4'h0;
        hold("irq_clr1b", 1, 4'hE);
        chk("irq.status_idle", status, 4'h0);
        chk("irq.irq_idle", {3'b0, irq}, 4'h0);

        raw[0] = 1'b1;
        hold("irq_rise_wait", 2, 4'hE);
        tick("irq_rise", 4'hF, 4'h1, 4'h0);
        hold("irq_rise_after", 1, 4'hF);
        chk("irq.status_rise", status, 4'h1);
        chk("irq.irq_lag", {3'b0, irq}, 4'h0);
        hold("irq_rise_after2", 1, 4'hF);
        chk("irq.irq_set", {3'b0, irq}, 4'h1);

        // Clear coincident with a fall: set wins.
        raw[0] = 1'b0;
        hold("irq_fall_wait", 2, 4'hF);
        tick("irq_fall", 4'hE, 4'h0, 4'h1);
        clr = 4'h1;
        hold("irq_fall_clr", 1, 4'hE);
        chk("irq.status_set_wins", status, 4'h1);
        chk("irq.irq_held", {3'b0, irq}, 4'h1);
        hold("irq_clr2", 1, 4'hE);
        chk("irq.status_dropped", status, 4'h0);
        chk("irq.irq_still_high", {3'b0, irq}, 4'h1);
        clr = 4'h0;
        hold("irq_clr2b", 1, 4'hE);
        chk("irq.irq_dropped", {3'b0, irq}, 4'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
